// File: rtl/vx_warp_ibuffer_if.sv
`default_nettype none
// ============================================================================
// Module      : vx_warp_ibuffer_if
// Description : Decode-side, flush and per-warp issue-side signals of the
//               warp instruction buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface vx_warp_ibuffer_if #(
  parameter int NUM_WARPS = 4,
  parameter int DEPTH     = 4,
  parameter int DATAW     = 64,
  parameter int NW_BITS   = $clog2(NUM_WARPS),
  parameter int CNTW      = $clog2(DEPTH + 1)
);
  logic                      decode_valid;
  logic [NW_BITS-1:0]        decode_wid;
  logic [DATAW-1:0]          decode_data;
  logic                      decode_ready;
  logic                      flush_valid;
  logic [NW_BITS-1:0]        flush_wid;
  logic [NUM_WARPS-1:0]      ibuf_valid;
  logic [NUM_WARPS*DATAW-1:0] ibuf_data;
  logic [NUM_WARPS-1:0]      ibuf_ready;
  logic [NUM_WARPS*CNTW-1:0] ibuf_count;

  // master: decode/scheduler environment; slave: the instruction buffer
  modport master (
    output decode_valid, decode_wid, decode_data, flush_valid, flush_wid, ibuf_ready,
    input  decode_ready, ibuf_valid, ibuf_data, ibuf_count
  );
  modport slave (
    input  decode_valid, decode_wid, decode_data, flush_valid, flush_wid, ibuf_ready,
    output decode_ready, ibuf_valid, ibuf_data, ibuf_count
  );
endinterface
`default_nettype wire

// File: rtl/vx_warp_ibuffer.sv
`default_nettype none
// ============================================================================
// Module      : vx_warp_ibuffer
// Description : Per-warp circular instruction FIFOs between decode and issue,
//               with per-warp flush.
// Revision    : 1.0 - initial release
// ============================================================================
module vx_warp_ibuffer #(
  parameter int NUM_WARPS = 4,
  parameter int DEPTH     = 4,
  parameter int DATAW     = 64
) (
  input  wire               clk,
  input  wire               reset,
  vx_warp_ibuffer_if.slave  ib
);
  localparam int NW_BITS = $clog2(NUM_WARPS);
  localparam int PTRW    = $clog2(DEPTH);
  localparam int CNTW    = $clog2(DEPTH + 1);

  logic [NUM_WARPS-1:0]       w_full;
  logic [NUM_WARPS-1:0]       w_valid;
  logic [NUM_WARPS*DATAW-1:0] w_data;
  logic [NUM_WARPS*CNTW-1:0]  w_count;
  logic                       w_decode_ready;

  // Registered counts only: no full-bypass even if the same warp pops this cycle.
  assign w_decode_ready = !reset && !w_full[ib.decode_wid]
                          && !(ib.flush_valid && (ib.flush_wid == ib.decode_wid));

  assign ib.decode_ready = w_decode_ready;
  assign ib.ibuf_valid   = w_valid;
  assign ib.ibuf_data    = w_data;
  assign ib.ibuf_count   = w_count;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    logic [DATAW-1:0] r_mem [DEPTH];
    logic [PTRW-1:0]  r_rd_ptr;
    logic [PTRW-1:0]  r_wr_ptr;
    logic [CNTW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;
    logic             w_flush;

    assign w_flush = ib.flush_valid && (ib.flush_wid == NW_BITS'(w));
    assign w_push  = ib.decode_valid && w_decode_ready && (ib.decode_wid == NW_BITS'(w));
    assign w_pop   = (r_count != '0) && ib.ibuf_ready[w];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else if (w_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push && !w_pop)      r_count <= r_count + 1'b1;
        else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= ib.decode_data;
    end

    assign w_full[w]                  = (r_count == CNTW'(DEPTH));
    assign w_valid[w]                 = (r_count != '0);
    assign w_data[w*DATAW +: DATAW]   = r_mem[r_rd_ptr];
    assign w_count[w*CNTW +: CNTW]    = r_count;

    a_count_max: assert property (@(posedge clk) disable iff (reset)
      r_count <= CNTW'(DEPTH));
  end

  // Only a non-power-of-two warp count leaves unused warp ids.
  if ((2 ** NW_BITS) != NUM_WARPS) begin : g_wid_chk
    a_wid_range: assert property (@(posedge clk) disable iff (reset)
      ib.decode_valid |-> (int'(ib.decode_wid) < NUM_WARPS));
  end

  a_hold_stable: assert property (@(posedge clk) disable iff (reset)
    (ib.decode_valid && !w_decode_ready) |=>
      ($stable(ib.decode_wid) && $stable(ib.decode_data)));

endmodule
`default_nettype wire
